alu_writeback: RTL and testbench

Sequencing and writeback stage downstream of `alu_core`. It accepts an ALU request, drives and holds `alu_opcode` long enough for the ALU outputs to settle, then captures the results. It commits them into the architectural ACC, B and PSW registers according to per-opcode write rules, and arbitrates against direct SFR-bus writes to the same registers. Its ACC and PSW outputs feed `op_in_1` and `carry_in`/`aux_carry_in` back into the ALU.

---
 rtl/alu_writeback.sv | 153 +++++++++++++++
 tb/tb_alu_writeback.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Sequencing and writeback stage behind alu_core: holds the ALU opcode through
// SETTLE/CAPTURE, then commits results into ACC, B and PSW, arbitrating with SFR writes.
module alu_writeback #(
    parameter logic [4:0] IDLE_OPC = 5'b11111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] req_opcode,
    input  logic       req_bit_op,
    output logic [4:0] alu_opcode,
    input  logic [7:0] alu_res_1,
    input  logic [7:0] alu_res_2,
    input  logic       alu_cy,
    input  logic       alu_ac,
    input  logic       alu_ov,
    input  logic       sfr_we,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    output logic [7:0] acc,
    output logic [7:0] b_reg,
    output logic [7:0] psw,
    output logic       busy,
    output logic       done
);

    // ALU_* codes, matching define_opcodes.v
    localparam logic [4:0] ALU_INC  = 5'd0;
    localparam logic [4:0] ALU_DEC  = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_ADDC = 5'd3;
    localparam logic [4:0] ALU_SUBB = 5'd4;
    localparam logic [4:0] ALU_MUL  = 5'd5;
    localparam logic [4:0] ALU_DIV  = 5'd6;
    localparam logic [4:0] ALU_DA   = 5'd7;
    localparam logic [4:0] ALU_CPL  = 5'd8;
    localparam logic [4:0] ALU_RR   = 5'd9;
    localparam logic [4:0] ALU_RRC  = 5'd10;
    localparam logic [4:0] ALU_RL   = 5'd11;
    localparam logic [4:0] ALU_RLC  = 5'd12;
    localparam logic [4:0] ALU_SWAP = 5'd13;
    localparam logic [4:0] ALU_ORL  = 5'd14;
    localparam logic [4:0] ALU_ANL  = 5'd15;
    localparam logic [4:0] ALU_XRL  = 5'd16;

    localparam logic [7:0] ADDR_ACC = 8'hE0;
    localparam logic [7:0] ADDR_B   = 8'hF0;
    localparam logic [7:0] ADDR_PSW = 8'hD0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] op_q;
    logic       bit_q;
    logic [7:1] psw_q;

    logic wr_acc, wr_b, wr_cy, wr_ac, wr_ov;
    logic cy_val;

    always_comb begin
        wr_acc = 1'b0;
        wr_b   = 1'b0;
        wr_cy  = 1'b0;
        wr_ac  = 1'b0;
        wr_ov  = 1'b0;
        cy_val = alu_cy;
        if (state == CAPTURE) begin
            unique case (op_q)
                ALU_INC, ALU_DEC, ALU_RR, ALU_RL, ALU_CPL, ALU_SWAP, ALU_DA, ALU_XRL:
                    wr_acc = 1'b1;
                ALU_ADD, ALU_ADDC, ALU_SUBB: begin
                    wr_acc = 1'b1;
                    wr_cy  = 1'b1;
                    wr_ac  = 1'b1;
                    wr_ov  = 1'b1;
                end
                ALU_MUL, ALU_DIV: begin
                    wr_acc = 1'b1;
                    wr_b   = 1'b1;
                    wr_cy  = 1'b1;
                    cy_val = 1'b0;
                    wr_ov  = 1'b1;
                end
                ALU_RRC, ALU_RLC: begin
                    wr_acc = 1'b1;
                    wr_cy  = 1'b1;
                end
                ALU_ORL, ALU_ANL: begin
                    wr_cy  = bit_q;
                    wr_acc = ~bit_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= IDLE_OPC;
            bit_q      <= 1'b0;
            acc        <= '0;
            b_reg      <= '0;
            psw_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            alu_opcode <= IDLE_OPC;
        end else begin
            // SFR write first; commit assignments below override per field
            if (sfr_we) begin
                case (sfr_addr)
                    ADDR_ACC: acc   <= sfr_wdata;
                    ADDR_B:   b_reg <= sfr_wdata;
                    ADDR_PSW: psw_q <= sfr_wdata[7:1];
                    default: ;
                endcase
            end
            if (wr_acc) acc      <= alu_res_1;
            if (wr_b)   b_reg    <= alu_res_2;
            if (wr_cy)  psw_q[7] <= cy_val;
            if (wr_ac)  psw_q[6] <= alu_ac;
            if (wr_ov)  psw_q[2] <= alu_ov;

            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        op_q       <= req_opcode;
                        bit_q      <= req_bit_op;
                        busy       <= 1'b1;
                        alu_opcode <= req_opcode;
                    end
                end
                SETTLE: state <= CAPTURE;
                CAPTURE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    alu_opcode <= IDLE_OPC;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign psw = {psw_q, ^acc};

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_alu_writeback;

    localparam logic [4:0] IDLE_OPC = 5'b11111;
    localparam logic [4:0] OP_INC = 5'd0,  OP_DEC = 5'd1,  OP_ADD = 5'd2,  OP_ADDC = 5'd3;
    localparam logic [4:0] OP_SUBB = 5'd4, OP_MUL = 5'd5,  OP_DIV = 5'd6,  OP_DA = 5'd7;
    localparam logic [4:0] OP_CPL = 5'd8,  OP_RR = 5'd9,   OP_RRC = 5'd10, OP_RL = 5'd11;
    localparam logic [4:0] OP_RLC = 5'd12, OP_SWAP = 5'd13, OP_ORL = 5'd14, OP_ANL = 5'd15;
    localparam logic [4:0] OP_XRL = 5'd16;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] req_opcode;
    logic       req_bit_op;
    logic [4:0] alu_opcode;
    logic [7:0] alu_res_1, alu_res_2;
    logic       alu_cy, alu_ac, alu_ov;
    logic       sfr_we;
    logic [7:0] sfr_addr, sfr_wdata;
    logic [7:0] acc, b_reg, psw;
    logic       busy, done;

    alu_writeback #(.IDLE_OPC(IDLE_OPC)) dut (
        .clock(clock), .reset(reset), .start(start), .req_opcode(req_opcode),
        .req_bit_op(req_bit_op), .alu_opcode(alu_opcode), .alu_res_1(alu_res_1),
        .alu_res_2(alu_res_2), .alu_cy(alu_cy), .alu_ac(alu_ac), .alu_ov(alu_ov),
        .sfr_we(sfr_we), .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata),
        .acc(acc), .b_reg(b_reg), .psw(psw), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: register file plus "cycles into the request" counter
    logic [7:0] m_acc = '0, m_b = '0, m_flags = '0;
    int         m_phase = 0;
    logic [4:0] m_op = IDLE_OPC;
    logic       m_bit = 1'b0;
    logic       m_done = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What a commit of this request writes: which fields and with what values
    task automatic commit_effect(input logic [4:0] op, input logic bitop,
                                 output logic w_acc, output logic w_b,
                                 output logic [7:0] pmask, output logic [7:0] pval);
        w_acc = 1'b0; w_b = 1'b0; pmask = 8'h00; pval = 8'h00;
        if (op inside {OP_INC, OP_DEC, OP_RR, OP_RL, OP_CPL, OP_SWAP, OP_DA, OP_XRL}) begin
            w_acc = 1'b1;
        end else if (op inside {OP_ADD, OP_ADDC, OP_SUBB}) begin
            w_acc = 1'b1; pmask = 8'hC4;
            pval = (alu_cy ? 8'h80 : 8'h00) | (alu_ac ? 8'h40 : 8'h00) | (alu_ov ? 8'h04 : 8'h00);
        end else if (op inside {OP_MUL, OP_DIV}) begin
            w_acc = 1'b1; w_b = 1'b1; pmask = 8'h84;
            pval = alu_ov ? 8'h04 : 8'h00;
        end else if (op inside {OP_RRC, OP_RLC}) begin
            w_acc = 1'b1; pmask = 8'h80; pval = alu_cy ? 8'h80 : 8'h00;
        end else if (op inside {OP_ORL, OP_ANL}) begin
            if (bitop) begin
                pmask = 8'h80; pval = alu_cy ? 8'h80 : 8'h00;
            end else begin
                w_acc = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        logic w_acc, w_b;
        logic [7:0] pmask, pval;
        if (!reset) begin
            m_acc = '0; m_b = '0; m_flags = '0; m_phase = 0; m_done = 1'b0;
            return;
        end
        if (sfr_we) begin
            if (sfr_addr == 8'hE0) m_acc = sfr_wdata;
            else if (sfr_addr == 8'hF0) m_b = sfr_wdata;
            else if (sfr_addr == 8'hD0) m_flags = sfr_wdata & 8'hFE;
        end
        m_done = (m_phase == 2);
        if (m_phase == 2) begin
            commit_effect(m_op, m_bit, w_acc, w_b, pmask, pval);
            if (w_acc) m_acc = alu_res_1;
            if (w_b)   m_b = alu_res_2;
            m_flags = (m_flags & ~pmask) | (pval & pmask);
        end
        if (m_phase == 0) begin
            if (start) begin
                m_phase = 1; m_op = req_opcode; m_bit = req_bit_op;
            end
        end else begin
            m_phase = (m_phase + 1) % 3;
        end
    endtask

    task automatic compare_all();
        chk("acc", acc, m_acc);
        chk("b_reg", b_reg, m_b);
        chk("psw", psw, {m_flags[7:1], ^m_acc});
        chk("busy", {7'd0, busy}, {7'd0, m_phase != 0});
        chk("done", {7'd0, done}, {7'd0, m_done});
        chk("alu_opcode", {3'd0, alu_opcode}, {3'd0, (m_phase != 0) ? m_op : IDLE_OPC});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic set_alu(input logic [7:0] r1, input logic [7:0] r2,
                           input logic cy, input logic ac, input logic ov);
        alu_res_1 = r1; alu_res_2 = r2; alu_cy = cy; alu_ac = ac; alu_ov = ov;
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        sfr_we = 1'b1; sfr_addr = a; sfr_wdata = d;
        tick();
        sfr_we = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] op, input logic bitop);
        start = 1'b1; req_opcode = op; req_bit_op = bitop;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    int done_cnt;

    initial begin
        reset = 1'b0; start = 1'b0; req_opcode = '0; req_bit_op = 1'b0;
        set_alu(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        sfr_we = 1'b0; sfr_addr = '0; sfr_wdata = '0;
        #2;
        tick();
        tick();
        chk("reset_acc", acc, 8'h00);
        chk("reset_psw", psw, 8'h00);
        chk("reset_opc", {3'd0, alu_opcode}, {3'd0, IDLE_OPC});
        reset = 1'b1;
        tick();

        // ADD
        set_alu(8'h89, 8'h00, 1'b0, 1'b1, 1'b1);
        run_op(OP_ADD, 1'b0);
        chk("add_done", {7'd0, done}, 8'd1);
        chk("add_acc", acc, 8'h89);
        chk("add_psw", psw, 8'h45);

        // MUL with CY preset
        sfr_write(8'hD0, 8'h80);
        set_alu(8'h20, 8'h01, 1'b1, 1'b0, 1'b1);
        run_op(OP_MUL, 1'b0);
        chk("mul_acc", acc, 8'h20);
        chk("mul_b", b_reg, 8'h01);
        chk("mul_psw", psw, 8'h05);

        // ORL bit form
        sfr_write(8'hE0, 8'h5A);
        sfr_write(8'hD0, 8'h00);
        set_alu(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(OP_ORL, 1'b1);
        chk("orl_acc", acc, 8'h5A);
        chk("orl_psw", psw, 8'h80);

        // commit and PSW write on the same edge
        set_alu(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        start = 1'b1; req_opcode = OP_ADDC; req_bit_op = 1'b0;
        tick();
        start = 1'b0;
        tick();
        sfr_we = 1'b1; sfr_addr = 8'hD0; sfr_wdata = 8'h18;
        tick();
        sfr_we = 1'b0;
        chk("coll_acc", acc, 8'h00);
        chk("coll_psw", psw, 8'h98);

        // start held for 6 cycles
        set_alu(8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
        start = 1'b1; req_opcode = OP_INC; done_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (done) done_cnt++;
            chk("held_done_cycle", {7'd0, done}, {7'd0, (i == 3) || (i == 6)});
        end
        start = 1'b0;
        chk("held_done_count", done_cnt[7:0], 8'd2);
        tick();

        // reset during CAPTURE of SUBB
        set_alu(8'hC3, 8'h00, 1'b1, 1'b1, 1'b1);
        start = 1'b1; req_opcode = OP_SUBB;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_acc", acc, 8'h00);
        chk("rst_psw", psw, 8'h00);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_commit", {7'd0, done}, 8'd0);
        end

        // unrecognised opcode and ignored SFR address
        sfr_write(8'hE0, 8'h3C);
        sfr_write(8'h81, 8'hFF);
        set_alu(8'hEE, 8'hDD, 1'b1, 1'b1, 1'b1);
        run_op(5'd20, 1'b0);
        chk("unk_done", {7'd0, done}, 8'd1);
        chk("unk_acc", acc, 8'h3C);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            start      = ($urandom_range(0, 2) == 0);
            req_opcode = 5'($urandom_range(0, 31));
            req_bit_op = 1'($urandom_range(0, 1));
            set_alu(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            sfr_we    = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: sfr_addr = 8'hE0;
                1: sfr_addr = 8'hF0;
                2: sfr_addr = 8'hD0;
                default: sfr_addr = 8'($urandom);
            endcase
            sfr_wdata = 8'($urandom);
            reset     = ($urandom_range(0, 60) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
